// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared types and constants for the decode-stage hazard scoreboard.
// Optional perf counters are enabled with HAZ_PERF_CNT_EN.
package id_hazard_scoreboard_pkg;

  localparam int MAX_REG_W = 6;

  localparam int FWD_RF = 0;
  localparam int EX     = 1;
  localparam int MEM    = 2;
  localparam int WB     = 3;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] dst;
    logic                 rf_wr;
    logic                 is_load;
    logic                 flag_wr;
  } entry_t;

  localparam entry_t ENTRY_BUBBLE = '0;

endpackage

// File: rtl/id_hazard_scoreboard_if.sv
// Decode-side bundle: ID controls in, stall/forward selects out.
// Counter outputs exist only under HAZ_PERF_CNT_EN.
interface id_hazard_scoreboard_if #(
  parameter int REG_W = 4,
  parameter int SEL_W = 2
);
  logic             id_valid;
  logic [REG_W-1:0] id_src1;
  logic [REG_W-1:0] id_src2;
  logic             id_src1_en;
  logic             id_src2_en;
  logic [REG_W-1:0] id_dst;
  logic             id_rf_wr;
  logic             id_is_load;
  logic             id_flag_wr;
  logic             id_br_reg;
  logic             id_br_flag;
  logic             flush;
  logic             freeze;
  logic             stall;
  logic [SEL_W-1:0] fwd_sel1;
  logic [SEL_W-1:0] fwd_sel2;
  logic             busy;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0]      stall_cycles;
  logic [31:0]      load_use_cnt;
`endif

  modport master (
    output id_valid, id_src1, id_src2,
    output id_src1_en, id_src2_en,
    output id_dst, id_rf_wr, id_is_load,
    output id_flag_wr, id_br_reg, id_br_flag,
    output flush, freeze,
`ifdef HAZ_PERF_CNT_EN
    input  stall_cycles, load_use_cnt,
`endif
    input  stall, fwd_sel1, fwd_sel2, busy
  );

  modport slave (
    input  id_valid, id_src1, id_src2,
    input  id_src1_en, id_src2_en,
    input  id_dst, id_rf_wr, id_is_load,
    input  id_flag_wr, id_br_reg, id_br_flag,
    input  flush, freeze,
`ifdef HAZ_PERF_CNT_EN
    output stall_cycles, load_use_cnt,
`endif
    output stall, fwd_sel1, fwd_sel2, busy
  );

endinterface

// File: rtl/id_hazard_scoreboard_match.sv
// Youngest-writer search over in-flight entries for one source index.
// Entry k = instruction that left ID k cycles ago; smallest k wins.
module haz_match_prio
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int PIPE_DEPTH = 3,
  parameter int REG_W      = 4,
  parameter int SEL_W      = 2
) (
  input  logic [REG_W-1:0]          src_i,
  input  logic                      src_en_i,
  input  entry_t [PIPE_DEPTH-1:1]   ent_i,
  output logic                      hit_o,
  output logic [SEL_W-1:0]          idx_o,
  output logic                      load_o
);

  logic unused_flags;

  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    load_o = 1'b0;
    for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
      if (ent_i[k].valid && ent_i[k].rf_wr &&
          ent_i[k].dst == MAX_REG_W'(src_i) &&
          src_i != '0 && src_en_i) begin
        hit_o  = 1'b1;
        idx_o  = SEL_W'(k);
        load_o = ent_i[k].is_load;
      end
    end
  end

  always_comb begin
    unused_flags = 1'b0;
    for (int k = 1; k < PIPE_DEPTH; k++)
      unused_flags = unused_flags ^ ent_i[k].flag_wr;
  end

endmodule

// File: rtl/id_hazard_scoreboard.sv
// Decode hazard scoreboard: aged in-flight write tracker, stall and EX forwarding.
// Define HAZ_PERF_CNT_EN to add saturating stall/load-use cycle counters.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 16,
  parameter int REG_W      = 4,
  parameter int PIPE_DEPTH = 3,
  parameter int LOAD_LAT   = 2,
  parameter int SEL_W      = 2
) (
  input logic                   clk,
  input logic                   rst,
  id_hazard_scoreboard_if.slave sb
);

  if (NUM_REGS > (1 << REG_W) || REG_W > MAX_REG_W ||
      PIPE_DEPTH < 2 || LOAD_LAT < 1 ||
      LOAD_LAT > PIPE_DEPTH) begin : g_bad_cfg
    $error("id_hazard_scoreboard: bad parameters");
  end

  localparam logic [SEL_W-1:0] LL = SEL_W'(LOAD_LAT);

  entry_t [PIPE_DEPTH:1] ent_q;
  entry_t [PIPE_DEPTH:1] ent_d;

  logic             hit1, hit2;
  logic             ld1, ld2;
  logic [SEL_W-1:0] idx1, idx2;
  logic             lu1, lu2;
  logic             br_stall, flag_stall;
  logic             stall_w, issue, busy_w;
  logic             unused_last;

  // Branch operand reuses the src1 search; a branch reads src1 in ID.
  haz_match_prio #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .REG_W      (REG_W),
    .SEL_W      (SEL_W)
  ) u_match1 (
    .src_i    (sb.id_src1),
    .src_en_i (sb.id_src1_en | sb.id_br_reg),
    .ent_i    (ent_q[PIPE_DEPTH-1:1]),
    .hit_o    (hit1),
    .idx_o    (idx1),
    .load_o   (ld1)
  );

  haz_match_prio #(
    .PIPE_DEPTH (PIPE_DEPTH),
    .REG_W      (REG_W),
    .SEL_W      (SEL_W)
  ) u_match2 (
    .src_i    (sb.id_src2),
    .src_en_i (sb.id_src2_en),
    .ent_i    (ent_q[PIPE_DEPTH-1:1]),
    .hit_o    (hit2),
    .idx_o    (idx2),
    .load_o   (ld2)
  );

  assign lu1 = hit1 & ld1 & (idx1 < LL);
  assign lu2 = hit2 & ld2 & (idx2 < LL);

  assign br_stall   = sb.id_br_reg & hit1;
  assign flag_stall = sb.id_br_flag & ent_q[EX].valid &
                      ent_q[EX].flag_wr;

  assign stall_w = sb.id_valid & ~sb.flush &
                   (lu1 | lu2 | br_stall | flag_stall);
  assign issue   = sb.id_valid & ~stall_w & ~sb.flush;

  always_comb begin
    ent_d = ent_q;
    if (!sb.freeze) begin
      for (int k = PIPE_DEPTH; k >= 2; k--)
        ent_d[k] = ent_q[k-1];
      ent_d[EX] = ENTRY_BUBBLE;
      if (issue) begin
        ent_d[EX].valid   = 1'b1;
        ent_d[EX].dst     = MAX_REG_W'(sb.id_dst);
        ent_d[EX].rf_wr   = sb.id_rf_wr;
        ent_d[EX].is_load = sb.id_is_load;
        ent_d[EX].flag_wr = sb.id_flag_wr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) ent_q <= '0;
    else      ent_q <= ent_d;
  end

  always_comb begin
    busy_w = 1'b0;
    for (int k = 1; k <= PIPE_DEPTH; k++)
      busy_w = busy_w | ent_q[k].valid;
  end

  assign unused_last = ^{ent_q[PIPE_DEPTH].dst,
                         ent_q[PIPE_DEPTH].rf_wr,
                         ent_q[PIPE_DEPTH].is_load,
                         ent_q[PIPE_DEPTH].flag_wr};

  assign sb.stall    = stall_w;
  assign sb.busy     = busy_w;
  assign sb.fwd_sel1 = hit1 ? idx1 + SEL_W'(1)
                            : SEL_W'(FWD_RF);
  assign sb.fwd_sel2 = hit2 ? idx2 + SEL_W'(1)
                            : SEL_W'(FWD_RF);

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] lu_cnt_q, lu_cnt_d;
  logic        cnt_stall, cnt_lu;

  assign cnt_stall = stall_w & ~sb.freeze;
  assign cnt_lu    = cnt_stall & (lu1 | lu2);

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    lu_cnt_d    = lu_cnt_q;
    if (cnt_stall && !(&stall_cnt_q))
      stall_cnt_d = stall_cnt_q + 32'd1;
    if (cnt_lu && !(&lu_cnt_q))
      lu_cnt_d = lu_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      lu_cnt_q    <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      lu_cnt_q    <= lu_cnt_d;
    end
  end

  assign sb.stall_cycles = stall_cnt_q;
  assign sb.load_use_cnt = lu_cnt_q;
`endif

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed bench for id_hazard_scoreboard (LOAD_LAT=2 and LOAD_LAT=3).
// Inputs change 1ns after posedge; outputs are checked on negedge.
module tb_id_hazard_scoreboard;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  id_hazard_scoreboard_if #(.REG_W(4), .SEL_W(2)) bus ();
  id_hazard_scoreboard_if #(.REG_W(4), .SEL_W(2)) bus3 ();

  id_hazard_scoreboard #(
    .NUM_REGS(16), .REG_W(4), .PIPE_DEPTH(3),
    .LOAD_LAT(2), .SEL_W(2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .sb  (bus)
  );

  id_hazard_scoreboard #(
    .NUM_REGS(16), .REG_W(4), .PIPE_DEPTH(3),
    .LOAD_LAT(3), .SEL_W(2)
  ) u_dut3 (
    .clk (clk),
    .rst (rst),
    .sb  (bus3)
  );

  assign bus3.id_valid   = bus.id_valid;
  assign bus3.id_src1    = bus.id_src1;
  assign bus3.id_src2    = bus.id_src2;
  assign bus3.id_src1_en = bus.id_src1_en;
  assign bus3.id_src2_en = bus.id_src2_en;
  assign bus3.id_dst     = bus.id_dst;
  assign bus3.id_rf_wr   = bus.id_rf_wr;
  assign bus3.id_is_load = bus.id_is_load;
  assign bus3.id_flag_wr = bus.id_flag_wr;
  assign bus3.id_br_reg  = bus.id_br_reg;
  assign bus3.id_br_flag = bus.id_br_flag;
  assign bus3.flush      = bus.flush;
  assign bus3.freeze     = bus.freeze;

  task automatic drv(
    input logic       v,
    input logic [3:0] s1, input logic e1,
    input logic [3:0] s2, input logic e2,
    input logic [3:0] d,  input logic wr,
    input logic       ld, input logic fw,
    input logic       br, input logic bf
  );
    bus.id_valid   = v;
    bus.id_src1    = s1;
    bus.id_src1_en = e1;
    bus.id_src2    = s2;
    bus.id_src2_en = e2;
    bus.id_dst     = d;
    bus.id_rf_wr   = wr;
    bus.id_is_load = ld;
    bus.id_flag_wr = fw;
    bus.id_br_reg  = br;
    bus.id_br_flag = bf;
  endtask

  task automatic idle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.flush  = 1'b0;
    bus.freeze = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    idle();
    repeat (4) tick();
  endtask

  task automatic test_reset();
    idle();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.stall !== 1'b0 ||
        bus.fwd_sel1 !== 2'd0 || bus.fwd_sel2 !== 2'd0) begin
      errors++;
      $display("FAIL reset busy=%b stall=%b f1=%0d f2=%0d exp 0",
               bus.busy, bus.stall, bus.fwd_sel1, bus.fwd_sel2);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fwd_alu();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    tick();
    drv(1, 3, 1, 5, 1, 4, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd2 ||
        bus.fwd_sel2 !== 2'd0) begin
      errors++;
      $display("FAIL fwd_ex stall=%b f1=%0d f2=%0d exp 0/2/0",
               bus.stall, bus.fwd_sel1, bus.fwd_sel2);
    end
    tick();
    drv(1, 4, 1, 3, 1, 6, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd2 ||
        bus.fwd_sel2 !== 2'd3) begin
      errors++;
      $display("FAIL fwd_mem stall=%b f1=%0d f2=%0d exp 0/2/3",
               bus.stall, bus.fwd_sel1, bus.fwd_sel2);
    end
    tick();
    drv(1, 3, 1, 0, 0, 7, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.fwd_sel1 !== 2'd0 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL fwd_wb f1=%0d busy=%b exp 0/1",
               bus.fwd_sel1, bus.busy);
    end
    drain();
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL drain busy=%b exp 0", bus.busy);
    end
    tick();
  endtask

  task automatic test_load_use();
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    tick();
    drv(1, 2, 1, 1, 1, 6, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1 || bus3.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_c1 stall=%b stall3=%b exp 1/1",
               bus.stall, bus3.stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd3 ||
        bus3.stall !== 1'b1) begin
      errors++;
      $display("FAIL lu_c2 stall=%b f1=%0d stall3=%b exp 0/3/1",
               bus.stall, bus.fwd_sel1, bus3.stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus3.stall !== 1'b0 || bus3.fwd_sel1 !== 2'd0) begin
      errors++;
      $display("FAIL lu3_c3 stall3=%b f1=%0d exp 0/0",
               bus3.stall, bus3.fwd_sel1);
    end
    tick();
    drain();
  endtask

  task automatic test_youngest();
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 5, 1, 0, 0, 0, 0);
    tick();
    drv(1, 0, 0, 5, 1, 8, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.fwd_sel2 !== 2'd2 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL youngest f2=%0d stall=%b exp 2/0",
               bus.fwd_sel2, bus.stall);
    end
    tick();
    drain();
    drv(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    drv(1, 0, 1, 0, 1, 9, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd0 ||
        bus.fwd_sel2 !== 2'd0) begin
      errors++;
      $display("FAIL r0 stall=%b f1=%0d f2=%0d exp 0/0/0",
               bus.stall, bus.fwd_sel1, bus.fwd_sel2);
    end
    tick();
    drain();
  endtask

  task automatic test_branches();
    drv(1, 0, 0, 0, 0, 4, 1, 0, 1, 0, 0);
    tick();
    drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL bflag_c1 stall=%b exp 1", bus.stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL bflag_c2 stall=%b exp 0", bus.stall);
    end
    tick();
    drain();
    drv(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0);
    tick();
    drv(1, 7, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== (c < 2)) begin
        errors++;
        $display("FAIL breg_c%0d stall=%b exp %0d",
                 c, bus.stall, (c < 2));
      end
      tick();
    end
    drain();
  endtask

  task automatic test_freeze();
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    tick();
    drv(1, 2, 1, 0, 0, 6, 1, 0, 0, 0, 0);
    bus.freeze = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (bus.stall !== 1'b1 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL frz_c%0d stall=%b busy=%b exp 1/1",
                 c, bus.stall, bus.busy);
      end
      tick();
    end
    bus.freeze = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b1) begin
      errors++;
      $display("FAIL frz_rel1 stall=%b exp 1", bus.stall);
    end
    tick();
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd3) begin
      errors++;
      $display("FAIL frz_rel2 stall=%b f1=%0d exp 0/3",
               bus.stall, bus.fwd_sel1);
    end
    tick();
    drain();
  endtask

  task automatic test_flush();
    drv(1, 0, 0, 0, 0, 2, 1, 1, 0, 0, 0);
    tick();
    drv(1, 2, 1, 0, 0, 2, 1, 0, 0, 0, 0);
    bus.flush = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL flush stall=%b exp 0", bus.stall);
    end
    tick();
    bus.flush = 1'b0;
    drv(1, 2, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.stall !== 1'b0 || bus.fwd_sel1 !== 2'd3) begin
      errors++;
      $display("FAIL flush_bubble stall=%b f1=%0d exp 0/3",
               bus.stall, bus.fwd_sel1);
    end
    tick();
    drain();
  endtask

  task automatic test_reset_mid();
    drv(1, 0, 0, 0, 0, 3, 1, 0, 0, 0, 0);
    tick();
    drv(1, 3, 1, 0, 0, 4, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.fwd_sel1 !== 2'd2) begin
      errors++;
      $display("FAIL pre_rst busy=%b f1=%0d exp 1/2",
               bus.busy, bus.fwd_sel1);
    end
    #1;
    rst = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.fwd_sel1 !== 2'd0) begin
      errors++;
      $display("FAIL async_rst busy=%b f1=%0d exp 0/0",
               bus.busy, bus.fwd_sel1);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.fwd_sel1 !== 2'd0 || bus.stall !== 1'b0) begin
      errors++;
      $display("FAIL post_rst f1=%0d stall=%b exp 0/0",
               bus.fwd_sel1, bus.stall);
    end
    tick();
    drain();
  endtask

  initial begin
    idle();
    test_reset();
    test_fwd_alu();
    test_load_use();
    test_youngest();
    test_branches();
    test_freeze();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
